frame_decoder: RTL and testbench



---
 rtl/frame_decoder_pkg.sv | 55 +++++
 rtl/frame_decoder_if.sv | 41 ++++
 rtl/sprite_hit_calc.sv | 38 +++
 rtl/frame_decoder.sv | 197 +++++++++++++++++++
 tb/tb_frame_decoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/frame_decoder_pkg.sv
// frame_decoder_pkg
//   Shared sprite geometry, color encoding and SRAM layout. The sprite writer
//   imports the same definitions, so both sides agree on where each car's
//   pixels live.
//   Contents: geometry/width constants, ObjectID, decoder state type,
//   obj_base() (first SRAM word of an object), pick_nibble() (pixel extraction).
package frame_decoder_pkg;

  localparam int CAR_SIZE        = 32;
  localparam int COLOR_WIDTH     = 4;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int SRAM_ADDR_WIDTH = 20;
  localparam int COOR_WIDTH      = 10;
  localparam int PIX_PER_WORD    = SRAM_DATA_WIDTH / COLOR_WIDTH;

  localparam int CAR_LOG2  = $clog2(CAR_SIZE);
  localparam int IDX_W     = 2 * CAR_LOG2;
  localparam int NIB_SEL_W = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    MAP  = 2'd0,
    CAR1 = 2'd1,
    CAR2 = 2'd2
  } ObjectID;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_CMP,
    S_OUT
  } state_e;

  // Car k occupies words [(k-1)*CAR_SIZE^2/PIX_PER_WORD, +CAR_SIZE^2/PIX_PER_WORD).
  function automatic int unsigned obj_base(input ObjectID id);
    int unsigned base;
    case (id)
      CAR1:    base = 0;
      CAR2:    base = CAR_SIZE * CAR_SIZE / PIX_PER_WORD;
      default: base = 0;
    endcase
    return base;
  endfunction

  // Nibble 0 sits in the least-significant bits of the word.
  function automatic logic [COLOR_WIDTH-1:0] pick_nibble(
    input logic [SRAM_DATA_WIDTH-1:0] word,
    input logic [NIB_SEL_W-1:0]       sel
  );
    logic [SRAM_DATA_WIDTH-1:0] shifted;
    shifted = word >> (sel * COLOR_WIDTH);
    return shifted[COLOR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/frame_decoder_if.sv
// frame_decoder_if
//   Bundles the pixel request/response handshake and the SRAM read port of
//   the frame decoder. Signal names keep the decoder's point of view
//   (i_* into the decoder, o_* out of it).
//   slave  : the decoder itself.
//   master : display timing / SRAM mux / output stage side.
interface frame_decoder_if;
  import frame_decoder_pkg::*;

  logic                       i_req;
  logic [COOR_WIDTH-1:0]      i_x;
  logic [COOR_WIDTH-1:0]      i_y;
  logic [COLOR_WIDTH-1:0]     i_map_color;
  logic [COOR_WIDTH-1:0]      i_car1_x;
  logic [COOR_WIDTH-1:0]      i_car1_y;
  logic [COOR_WIDTH-1:0]      i_car2_x;
  logic [COOR_WIDTH-1:0]      i_car2_y;
  logic                       i_sram_writing;
  logic [SRAM_DATA_WIDTH-1:0] i_sram_rdata;
  logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr;
  logic                       o_sram_rd;
  logic                       o_ready;
  logic                       o_valid;
  logic [COLOR_WIDTH-1:0]     o_color;
  logic [1:0]                 o_object_id;

  modport slave (
    input  i_req, i_x, i_y, i_map_color,
    input  i_car1_x, i_car1_y, i_car2_x, i_car2_y,
    input  i_sram_writing, i_sram_rdata,
    output o_sram_addr, o_sram_rd, o_ready, o_valid, o_color, o_object_id
  );

  modport master (
    output i_req, i_x, i_y, i_map_color,
    output i_car1_x, i_car1_y, i_car2_x, i_car2_y,
    output i_sram_writing, i_sram_rdata,
    input  o_sram_addr, o_sram_rd, o_ready, o_valid, o_color, o_object_id
  );

endinterface

// File: rtl/sprite_hit_calc.sv
// sprite_hit_calc
//   Combinational hit test and SRAM location for one car sprite.
//   px_x/px_y   : screen pixel.
//   car_x/car_y : sprite top-left corner.
//   hit         : pixel falls inside the sprite (no wrap-around).
//   word_addr   : SRAM word holding the pixel (object base included).
//   nib_sel     : pixel position inside that word.
module sprite_hit_calc
  import frame_decoder_pkg::*;
#(
  parameter ObjectID OBJ = CAR1
) (
  input  logic [COOR_WIDTH-1:0]      px_x,
  input  logic [COOR_WIDTH-1:0]      px_y,
  input  logic [COOR_WIDTH-1:0]      car_x,
  input  logic [COOR_WIDTH-1:0]      car_y,
  output logic                       hit,
  output logic [SRAM_ADDR_WIDTH-1:0] word_addr,
  output logic [NIB_SEL_W-1:0]       nib_sel
);

  localparam logic [SRAM_ADDR_WIDTH-1:0] BASE = SRAM_ADDR_WIDTH'(obj_base(OBJ));

  logic [COOR_WIDTH:0] dx;
  logic [COOR_WIDTH:0] dy;
  logic [IDX_W-1:0]    idx;

  always_comb begin
    dx = {1'b0, px_x} - {1'b0, car_x};
    dy = {1'b0, px_y} - {1'b0, car_y};
    // Zero upper bits means both non-negative (sign bit clear) and < CAR_SIZE.
    hit = (dx[COOR_WIDTH:CAR_LOG2] == '0) && (dy[COOR_WIDTH:CAR_LOG2] == '0);
    idx = (IDX_W'(dy[CAR_LOG2-1:0]) << CAR_LOG2) | IDX_W'(dx[CAR_LOG2-1:0]);
    word_addr = BASE + SRAM_ADDR_WIDTH'(idx >> NIB_SEL_W);
    nib_sel   = idx[NIB_SEL_W-1:0];
  end

endmodule

// File: rtl/frame_decoder.sv
// frame_decoder
//   Reads both car sprites for one requested screen pixel out of SRAM and
//   composites them over the map color (car1 above car2 above map).
//   i_clk   : clock.
//   i_rst_n : synchronous active-low reset; drops any pending request.
//   bus     : request (i_req/o_ready, coordinates, map color, car positions),
//             result (o_valid pulse, o_color, o_object_id) and SRAM read
//             port (o_sram_addr/o_sram_rd, i_sram_rdata one cycle later,
//             i_sram_writing stalls reads).
module frame_decoder
  import frame_decoder_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  frame_decoder_if.slave bus
);

  state_e                 state_q, state_d;
  logic [COOR_WIDTH-1:0]  x_q, x_d;
  logic [COOR_WIDTH-1:0]  y_q, y_d;
  logic [COLOR_WIDTH-1:0] map_q, map_d;
  logic [COOR_WIDTH-1:0]  car1_x_q, car1_x_d;
  logic [COOR_WIDTH-1:0]  car1_y_q, car1_y_d;
  logic [COOR_WIDTH-1:0]  car2_x_q, car2_x_d;
  logic [COOR_WIDTH-1:0]  car2_y_q, car2_y_d;
  logic                   rd1_pend_q, rd1_pend_d;
  logic                   rd2_pend_q, rd2_pend_d;
  logic [COLOR_WIDTH-1:0] pix1_q, pix1_d;
  logic [COLOR_WIDTH-1:0] pix2_q, pix2_d;
  logic [COLOR_WIDTH-1:0] color_q, color_d;
  ObjectID                obj_q, obj_d;

  logic                       hit1, hit2;
  logic [SRAM_ADDR_WIDTH-1:0] addr1, addr2;
  logic [NIB_SEL_W-1:0]       sel1, sel2;
  logic                       sram_rd;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [COLOR_WIDTH-1:0]     pix2_now;

  sprite_hit_calc #(.OBJ(CAR1)) u_hit_car1 (
    .px_x      (x_q),
    .px_y      (y_q),
    .car_x     (car1_x_q),
    .car_y     (car1_y_q),
    .hit       (hit1),
    .word_addr (addr1),
    .nib_sel   (sel1)
  );

  sprite_hit_calc #(.OBJ(CAR2)) u_hit_car2 (
    .px_x      (x_q),
    .px_y      (y_q),
    .car_x     (car2_x_q),
    .car_y     (car2_y_q),
    .hit       (hit2),
    .word_addr (addr2),
    .nib_sel   (sel2)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    map_d      = map_q;
    car1_x_d   = car1_x_q;
    car1_y_d   = car1_y_q;
    car2_x_d   = car2_x_q;
    car2_y_d   = car2_y_q;
    rd1_pend_d = rd1_pend_q;
    rd2_pend_d = rd2_pend_q;
    pix1_d     = pix1_q;
    pix2_d     = pix2_q;
    color_d    = color_q;
    obj_d      = obj_q;
    sram_rd    = 1'b0;
    sram_addr  = '0;
    pix2_now   = pix2_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req) begin
          x_d        = bus.i_x;
          y_d        = bus.i_y;
          map_d      = bus.i_map_color;
          car1_x_d   = bus.i_car1_x;
          car1_y_d   = bus.i_car1_y;
          car2_x_d   = bus.i_car2_x;
          car2_y_d   = bus.i_car2_y;
          rd1_pend_d = 1'b0;
          rd2_pend_d = 1'b0;
          pix1_d     = '0;
          pix2_d     = '0;
          state_d    = S_RD1;
        end
      end

      S_RD1: begin
        if (!hit1) begin
          pix1_d  = '0;
          state_d = S_RD2;
        end else if (!bus.i_sram_writing) begin
          sram_rd    = 1'b1;
          sram_addr  = addr1;
          rd1_pend_d = 1'b1;
          state_d    = S_RD2;
        end
      end

      S_RD2: begin
        // rd1_pend is cleared on capture so a stall here cannot re-sample
        // rdata that no longer belongs to car1.
        if (rd1_pend_q) begin
          pix1_d     = pick_nibble(bus.i_sram_rdata, sel1);
          rd1_pend_d = 1'b0;
        end
        if (!hit2) begin
          pix2_d  = '0;
          state_d = S_CMP;
        end else if (!bus.i_sram_writing) begin
          sram_rd    = 1'b1;
          sram_addr  = addr2;
          rd2_pend_d = 1'b1;
          state_d    = S_CMP;
        end
      end

      S_CMP: begin
        if (rd2_pend_q) begin
          pix2_now = pick_nibble(bus.i_sram_rdata, sel2);
        end
        pix2_d     = pix2_now;
        rd2_pend_d = 1'b0;
        if (pix1_q != '0) begin
          color_d = pix1_q;
          obj_d   = CAR1;
        end else if (pix2_now != '0) begin
          color_d = pix2_now;
          obj_d   = CAR2;
        end else begin
          color_d = map_q;
          obj_d   = MAP;
        end
        state_d = S_OUT;
      end

      S_OUT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      map_q      <= '0;
      car1_x_q   <= '0;
      car1_y_q   <= '0;
      car2_x_q   <= '0;
      car2_y_q   <= '0;
      rd1_pend_q <= 1'b0;
      rd2_pend_q <= 1'b0;
      pix1_q     <= '0;
      pix2_q     <= '0;
      color_q    <= '0;
      obj_q      <= MAP;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      map_q      <= map_d;
      car1_x_q   <= car1_x_d;
      car1_y_q   <= car1_y_d;
      car2_x_q   <= car2_x_d;
      car2_y_q   <= car2_y_d;
      rd1_pend_q <= rd1_pend_d;
      rd2_pend_q <= rd2_pend_d;
      pix1_q     <= pix1_d;
      pix2_q     <= pix2_d;
      color_q    <= color_d;
      obj_q      <= obj_d;
    end
  end

  assign bus.o_ready     = (state_q == S_IDLE);
  assign bus.o_valid     = (state_q == S_OUT);
  assign bus.o_color     = color_q;
  assign bus.o_object_id = obj_q;
  assign bus.o_sram_rd   = sram_rd;
  assign bus.o_sram_addr = sram_addr;

endmodule

// File: tb/tb_frame_decoder.sv
// tb_frame_decoder
//   Self-checking bench: directed scenarios plus randomized pixels, car
//   positions, sprite contents and SRAM-busy patterns, compared against a
//   pixel-level reference model of the compositing and timing rules.
module tb_frame_decoder;
  import frame_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  frame_decoder_if bus();

  frame_decoder u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [15:0] mem [0:511];
  int n_checks = 0;
  int n_fails  = 0;

  // SRAM: one-cycle read latency; garbage on idle cycles.
  always @(posedge clk) begin
    if (bus.o_sram_rd) bus.i_sram_rdata <= mem[bus.o_sram_addr[8:0]];
    else               bus.i_sram_rdata <= 16'($urandom);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pixel-level model of one car: hit, word address and pixel value.
  task automatic ref_car(input int x, input int y, input int cx, input int cy,
                         input int k, output bit hit, output int addr, output int nib);
    int dx, dy, idx;
    dx   = x - cx;
    dy   = y - cy;
    hit  = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
    addr = 0;
    nib  = 0;
    if (hit) begin
      idx  = dy * 32 + dx;
      addr = (k - 1) * 256 + idx / 4;
      nib  = (int'(mem[addr]) >> (4 * (idx % 4))) & 15;
    end
  endtask

  // Entered and left at a negedge with the decoder idle.
  task automatic run_txn(input string tag, input int x, input int y, input int mapc,
                         input int c1x, input int c1y, input int c2x, input int c2y,
                         input logic [31:0] wr, input bit noisy);
    bit h1, h2;
    int a1, a2, n1, n2;
    int exp_color, exp_id, exp_cyc, got_cyc;
    int exp_addr[$];

    ref_car(x, y, c1x, c1y, 1, h1, a1, n1);
    ref_car(x, y, c2x, c2y, 2, h2, a2, n2);
    if (h1) exp_addr.push_back(a1);
    if (h2) exp_addr.push_back(a2);
    if (h1 && n1 != 0)      begin exp_color = n1;   exp_id = 1; end
    else if (h2 && n2 != 0) begin exp_color = n2;   exp_id = 2; end
    else                    begin exp_color = mapc; exp_id = 0; end
    // Each busy cycle delays a pending read by one cycle.
    exp_cyc = 1;
    if (h1) while (wr[exp_cyc]) exp_cyc++;
    exp_cyc++;
    if (h2) while (wr[exp_cyc]) exp_cyc++;
    exp_cyc += 2;

    check_eq({tag, "_ready_idle"}, int'(bus.o_ready), 1);
    bus.i_x            = COOR_WIDTH'(x);
    bus.i_y            = COOR_WIDTH'(y);
    bus.i_map_color    = COLOR_WIDTH'(mapc);
    bus.i_car1_x       = COOR_WIDTH'(c1x);
    bus.i_car1_y       = COOR_WIDTH'(c1y);
    bus.i_car2_x       = COOR_WIDTH'(c2x);
    bus.i_car2_y       = COOR_WIDTH'(c2y);
    bus.i_req          = 1'b1;
    bus.i_sram_writing = 1'b0;

    got_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      bus.i_req          = (noisy && c <= exp_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_sram_writing = (c < 32) ? wr[c] : 1'b0;
      @(negedge clk);
      if (c == 1) check_eq({tag, "_ready_busy"}, int'(bus.o_ready), 0);
      if (bus.o_sram_rd) begin
        if (bus.i_sram_writing) check_eq({tag, "_rd_while_writing"}, 1, 0);
        if (exp_addr.size() == 0) check_eq({tag, "_extra_rd"}, int'(bus.o_sram_addr), -1);
        else check_eq({tag, "_rd_addr"}, int'(bus.o_sram_addr), exp_addr.pop_front());
      end else if (bus.o_sram_addr != '0) begin
        check_eq({tag, "_addr_no_rd"}, int'(bus.o_sram_addr), 0);
      end
      if (bus.o_valid) begin
        got_cyc = c;
        break;
      end
    end
    check_eq({tag, "_valid_cycle"}, got_cyc, exp_cyc);
    check_eq({tag, "_color"}, int'(bus.o_color), exp_color);
    check_eq({tag, "_id"}, int'(bus.o_object_id), exp_id);
    check_eq({tag, "_reads_left"}, exp_addr.size(), 0);

    @(posedge clk);
    #1;
    bus.i_req          = 1'b0;
    bus.i_sram_writing = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ready_after"}, int'(bus.o_ready), 1);
    check_eq({tag, "_valid_once"}, int'(bus.o_valid), 0);
  endtask

  task automatic run_reset_mid();
    int pulses;
    bus.i_x      = 10'd101;  bus.i_y      = 10'd100;
    bus.i_car1_x = 10'd100;  bus.i_car1_y = 10'd100;
    bus.i_car2_x = 10'd900;  bus.i_car2_y = 10'd900;
    bus.i_map_color = 4'd5;
    bus.i_req = 1'b1;
    @(posedge clk); #1; bus.i_req = 1'b0;   // cycle 1: S_RD1
    @(posedge clk); #1; rst_n = 1'b0;       // cycle 2: S_RD2, reset sampled at its end
    @(posedge clk); #1;
    check_eq("rst_mid_ready", int'(bus.o_ready), 1);
    check_eq("rst_mid_valid", int'(bus.o_valid), 0);
    check_eq("rst_mid_color", int'(bus.o_color), 0);
    check_eq("rst_mid_id", int'(bus.o_object_id), 0);
    check_eq("rst_mid_rd", int'(bus.o_sram_rd), 0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_valid) pulses++;
    end
    check_eq("rst_mid_no_pulse", pulses, 0);
  endtask

  function automatic int near(input int p);
    int v;
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 1023));
    v = p - int'($urandom_range(0, 40)) + 4;
    return (v < 0) ? 0 : v;
  endfunction

  initial begin
    int px, py;
    logic [15:0] w;

    bus.i_req = 1'b0;  bus.i_x = '0;  bus.i_y = '0;  bus.i_map_color = '0;
    bus.i_car1_x = '0; bus.i_car1_y = '0; bus.i_car2_x = '0; bus.i_car2_y = '0;
    bus.i_sram_writing = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_ready", int'(bus.o_ready), 1);
    check_eq("reset_valid", int'(bus.o_valid), 0);
    check_eq("reset_color", int'(bus.o_color), 0);
    check_eq("reset_id", int'(bus.o_object_id), 0);
    check_eq("reset_rd", int'(bus.o_sram_rd), 0);
    check_eq("reset_addr", int'(bus.o_sram_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("miss", 10, 10, 5, 100, 100, 200, 200, 32'h0, 1'b0);

    mem[0] = 16'h00A0;
    run_txn("car1_hit", 101, 100, 5, 100, 100, 200, 200, 32'h0, 1'b0);

    run_reset_mid();

    mem[511] = 16'h9123;
    run_txn("car2_hit", 31, 31, 6, 500, 500, 0, 0, 32'h0, 1'b0);

    mem[0] = 16'h0003;  mem[256] = 16'h0007;
    run_txn("overlap_both", 50, 50, 1, 50, 50, 50, 50, 32'h0, 1'b0);
    mem[0] = 16'h0000;
    run_txn("overlap_clear1", 50, 50, 1, 50, 50, 50, 50, 32'h0, 1'b0);

    mem[0] = 16'h00B0;
    run_txn("stall_rd1", 101, 100, 4, 100, 100, 900, 900, 32'h0000_000E, 1'b0);
    run_txn("stall_both", 50, 50, 2, 50, 50, 50, 50, 32'h0000_0036, 1'b0);

    run_txn("edge_dx32", 132, 100, 2, 100, 100, 900, 900, 32'h0, 1'b0);
    run_txn("edge_dx31", 131, 131, 2, 100, 100, 900, 900, 32'h0, 1'b0);
    run_txn("no_wrap", 3, 3, 8, 1020, 1020, 1023, 0, 32'h0, 1'b0);

    for (int i = 0; i < 512; i++) begin
      w = '0;
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 1) == 1) w = w | (16'($urandom_range(1, 15)) << (4 * n));
      mem[i] = w;
    end

    for (int t = 0; t < 60; t++) begin
      px = int'($urandom_range(0, 120));
      py = int'($urandom_range(0, 120));
      run_txn("rnd", px, py, int'($urandom_range(0, 15)),
              near(px), near(py), near(px), near(py),
              $urandom & $urandom & 32'h0000_1FFE, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
